// File: rtl/arbitro_mem_if.sv
// Shared-memory arbiter bus: fetch port, MEM-stage data port and the single memory port.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface arbitro_mem_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_wh;
  logic [31:0] d_rdata;
  logic        d_ack;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        stall;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_wh, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           mem_be, stall, err
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_wh, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           mem_be, stall, err
  );
endinterface

// File: rtl/arbitro_mem.sv
// Arbiter sharing one memory port between instruction fetch and MEM-stage data accesses,
// with alternating priority on conflicts and a per-access timeout that forces completion.
module arbitro_mem #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          reloj,
  input  logic          resetM,
  arbitro_mem_if.slave  bus
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TIMEOUT_RD = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_t;

  state_t             state_q, state_d;
  logic               last_fetch_q, last_fetch_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               if_ack_q, if_ack_d;
  logic               d_ack_q, d_ack_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic               err_q, err_d;

  logic               fetch_pend;
  logic               data_pend;
  logic               timeout;
  logic               done;

  // State and latched port values
  always_ff @(posedge reloj or posedge resetM) begin
    if (resetM) begin
      state_q      <= IDLE;
      last_fetch_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      wait_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      wait_q       <= wait_d;
      err_q        <= err_d;
    end
  end

  // Next-state, grant and completion logic
  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    wait_d       = wait_q;
    err_d        = err_q;

    fetch_pend = bus.if_req;
    data_pend  = bus.d_rd | bus.d_wr;
    timeout    = (wait_q == CNT_W'(TIMEOUT - 1)) && !bus.mem_ready;
    done       = bus.mem_ready || timeout;

    case (state_q)
      IDLE: begin
        // On a conflict the port that did not win last time gets the grant
        if (fetch_pend && (!data_pend || !last_fetch_q)) begin
          state_d  = IF_ACC;
          addr_d   = bus.if_addr;
          wdata_d  = '0;
          be_d     = 4'b1111;
          mem_we_d = 1'b0;
          mem_en_d = 1'b1;
          wait_d   = '0;
        end else if (data_pend) begin
          state_d  = D_ACC;
          addr_d   = bus.d_addr;
          wdata_d  = bus.d_wdata;
          be_d     = bus.d_wh ? (bus.d_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          mem_we_d = bus.d_wr;
          mem_en_d = 1'b1;
          wait_d   = '0;
        end
      end

      IF_ACC, D_ACC: begin
        if (done) begin
          state_d      = RESP;
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
          last_fetch_d = (state_q == IF_ACC);
          if (timeout) err_d = 1'b1;
          if (state_q == IF_ACC) begin
            if_ack_d   = 1'b1;
            if_rdata_d = timeout ? TIMEOUT_RD : bus.mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            // Writes (including simultaneous rd+wr) leave the read data untouched
            if (!mem_we_q) d_rdata_d = timeout ? TIMEOUT_RD : bus.mem_rdata;
          end
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;

  // Pipeline freeze while any request is still waiting for its ack
  assign bus.stall = (bus.if_req & ~if_ack_q) | ((bus.d_rd | bus.d_wr) & ~d_ack_q);

endmodule

// File: tb/tb_arbitro_mem.sv
// Directed self-checking bench for arbitro_mem: fetch, conflict ordering, data byte
// enables, timeout, reset during an access and continuous alternating traffic.
module tb_arbitro_mem;

  logic reloj;
  logic resetM;
  int   checks;
  int   failures;
  logic [31:0] exp_drdata;

  arbitro_mem_if bus ();

  arbitro_mem #(.TIMEOUT(16)) dut (
    .reloj  (reloj),
    .resetM (resetM),
    .bus    (bus.slave)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic tick;
    @(posedge reloj);
    #1;
  endtask

  task automatic clear_inputs;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_rd      = 1'b0;
    bus.d_wr      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_wh      = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    resetM = 1'b1;
    @(posedge reloj);
    @(posedge reloj);
    #1;
    resetM = 1'b0;
    exp_drdata = '0;
  endtask

  task automatic test_reset;
    clear_inputs();
    resetM = 1'b0;
    #2;
    resetM = 1'b1;
    #1;
    checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL rst_mem_en got=%b exp=0", bus.mem_en); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (bus.mem_be !== 4'b0000) begin failures++; $display("FAIL rst_mem_be got=%b exp=0000", bus.mem_be); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if ({bus.if_ack, bus.d_ack} !== 2'b00) begin failures++; $display("FAIL rst_acks got=%b exp=00", {bus.if_ack, bus.d_ack}); end
    checks++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", bus.if_rdata, bus.d_rdata); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b exp=0", bus.stall); end
    do_reset();
  endtask

  task automatic test_fetch;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0010;
    #1;
    checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL fetch_c0_en got=%b exp=0", bus.mem_en); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL fetch_c0_stall got=%b exp=1", bus.stall); end
    tick();
    checks++; if (bus.mem_en !== 1'b1) begin failures++; $display("FAIL fetch_c1_en got=%b exp=1", bus.mem_en); end
    checks++; if (bus.mem_addr !== 32'h0000_0010) begin failures++; $display("FAIL fetch_c1_addr got=%h exp=00000010", bus.mem_addr); end
    checks++; if (bus.mem_be !== 4'b1111 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL fetch_c1_be_we got=%b/%b exp=1111/0", bus.mem_be, bus.mem_we); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h2008_0005;
    tick();
    checks++; if (bus.if_ack !== 1'b1 || bus.d_ack !== 1'b0) begin failures++; $display("FAIL fetch_c2_ack got=%b/%b exp=1/0", bus.if_ack, bus.d_ack); end
    checks++; if (bus.if_rdata !== 32'h2008_0005) begin failures++; $display("FAIL fetch_c2_rdata got=%h exp=20080005", bus.if_rdata); end
    checks++; if (bus.mem_en !== 1'b0) begin failures++; $display("FAIL fetch_c2_en got=%b exp=0", bus.mem_en); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL fetch_c2_stall got=%b exp=0", bus.stall); end
    clear_inputs();
    tick();
    checks++; if (bus.if_ack !== 1'b0) begin failures++; $display("FAIL fetch_c3_ack got=%b exp=0", bus.if_ack); end
  endtask

  task automatic test_conflict;
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0020;
    bus.d_rd    = 1'b1;
    bus.d_addr  = 32'h0000_0100;
    tick();
    checks++; if (bus.mem_addr !== 32'h0000_0020 || bus.mem_en !== 1'b1) begin failures++; $display("FAIL conf_first_grant got=%h/%b exp=00000020/1", bus.mem_addr, bus.mem_en); end
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL conf_stall got=%b exp=1", bus.stall); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h1111_1111;
    tick();
    checks++; if ({bus.if_ack, bus.d_ack} !== 2'b10) begin failures++; $display("FAIL conf_ack1 got=%b exp=10", {bus.if_ack, bus.d_ack}); end
    checks++; if (bus.if_rdata !== 32'h1111_1111) begin failures++; $display("FAIL conf_if_rdata got=%h exp=11111111", bus.if_rdata); end
    bus.if_req    = 1'b0;
    bus.mem_ready = 1'b0;
    tick();
    checks++; if ({bus.if_ack, bus.d_ack, bus.mem_en} !== 3'b000) begin failures++; $display("FAIL conf_gap got=%b exp=000", {bus.if_ack, bus.d_ack, bus.mem_en}); end
    tick();
    checks++; if (bus.mem_addr !== 32'h0000_0100 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL conf_second_grant got=%h/%b/%b exp=00000100/1/0", bus.mem_addr, bus.mem_en, bus.mem_we); end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h2222_2222;
    tick();
    checks++; if ({bus.if_ack, bus.d_ack} !== 2'b01) begin failures++; $display("FAIL conf_ack2 got=%b exp=01", {bus.if_ack, bus.d_ack}); end
    checks++; if (bus.d_rdata !== 32'h2222_2222) begin failures++; $display("FAIL conf_d_rdata got=%h exp=22222222", bus.d_rdata); end
    checks++; if (bus.if_rdata !== 32'h1111_1111) begin failures++; $display("FAIL conf_if_hold got=%h exp=11111111", bus.if_rdata); end
    exp_drdata = 32'h2222_2222;
    clear_inputs();
    tick();
  endtask

  task automatic test_data_access;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    logic        t_wh;
    logic        t_rd;
    logic        t_wr;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin t_addr = 32'h0000_0022; t_wh = 1'b1; t_rd = 1'b0; t_wr = 1'b1; t_be = 4'b1100; end
        1:       begin t_addr = 32'h0000_0020; t_wh = 1'b1; t_rd = 1'b0; t_wr = 1'b1; t_be = 4'b0011; end
        2:       begin t_addr = 32'h0000_0040; t_wh = 1'b0; t_rd = 1'b1; t_wr = 1'b1; t_be = 4'b1111; end
        default: begin t_addr = 32'h0000_0044; t_wh = 1'b0; t_rd = 1'b1; t_wr = 1'b0; t_be = 4'b1111; end
      endcase
      t_wdata = (i == 0) ? 32'h0000_ABCD : 32'h1234_0000 + 32'(i);
      bus.d_addr  = t_addr;
      bus.d_wdata = t_wdata;
      bus.d_wh    = t_wh;
      bus.d_rd    = t_rd;
      bus.d_wr    = t_wr;
      tick();
      checks++; if (bus.mem_be !== t_be || bus.mem_we !== t_wr) begin failures++; $display("FAIL data%0d_be_we got=%b/%b exp=%b/%b", i, bus.mem_be, bus.mem_we, t_be, t_wr); end
      checks++; if (bus.mem_addr !== t_addr || bus.mem_wdata !== t_wdata) begin failures++; $display("FAIL data%0d_addr_wdata got=%h/%h exp=%h/%h", i, bus.mem_addr, bus.mem_wdata, t_addr, t_wdata); end
      // Live inputs change mid-access; the port must keep the granted values
      bus.d_addr  = 32'hFFFF_FFFD;
      bus.d_wdata = 32'h0;
      bus.d_wh    = ~t_wh;
      tick();
      checks++; if (bus.mem_be !== t_be || bus.mem_addr !== t_addr || bus.mem_wdata !== t_wdata || bus.mem_en !== 1'b1) begin failures++; $display("FAIL data%0d_latched got=%b/%h/%h exp=%b/%h/%h", i, bus.mem_be, bus.mem_addr, bus.mem_wdata, t_be, t_addr, t_wdata); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hC0DE_0000 + 32'(i);
      if (!t_wr) exp_drdata = 32'hC0DE_0000 + 32'(i);
      tick();
      checks++; if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL data%0d_ack got=%b exp=1", i, bus.d_ack); end
      checks++; if (bus.d_rdata !== exp_drdata) begin failures++; $display("FAIL data%0d_rdata got=%h exp=%h", i, bus.d_rdata, exp_drdata); end
      clear_inputs();
      tick();
    end
  endtask

  task automatic test_timeout;
    bus.d_rd   = 1'b1;
    bus.d_addr = 32'h0000_0080;
    for (int c = 1; c <= 16; c++) begin
      tick();
      checks++; if (bus.mem_en !== 1'b1 || bus.d_ack !== 1'b0) begin failures++; $display("FAIL tmo_wait_c%0d got=%b/%b exp=1/0", c, bus.mem_en, bus.d_ack); end
    end
    tick();
    checks++; if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL tmo_ack_c17 got=%b exp=1", bus.d_ack); end
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b exp=1", bus.err); end
    checks++; if (bus.d_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL tmo_rdata got=%h exp=deadbeef", bus.d_rdata); end
    clear_inputs();
    tick();
    tick();
    checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky got=%b exp=1", bus.err); end
  endtask

  task automatic test_reset_mid_access;
    bus.d_rd   = 1'b1;
    bus.d_addr = 32'h0000_0200;
    tick();
    tick();
    checks++; if (bus.mem_en !== 1'b1 || bus.err !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b/%b exp=1/1", bus.mem_en, bus.err); end
    #2;
    resetM = 1'b1;
    #1;
    checks++; if (bus.mem_en !== 1'b0 || bus.d_ack !== 1'b0) begin failures++; $display("FAIL rmid_async got=%b/%b exp=0/0", bus.mem_en, bus.d_ack); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rmid_err_clear got=%b exp=0", bus.err); end
    bus.d_rd = 1'b0;
    @(posedge reloj);
    #1;
    resetM = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus.d_ack !== 1'b0 || bus.mem_en !== 1'b0) begin failures++; $display("FAIL rmid_after%0d got=%b/%b exp=0/0", c, bus.d_ack, bus.mem_en); end
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0300;
    tick();
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h0000_0300) begin failures++; $display("FAIL rmid_idle_grant got=%b/%h exp=1/00000300", bus.mem_en, bus.mem_addr); end
    bus.mem_ready = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    logic exp_if;
    logic exp_d;
    do_reset();
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h0000_0300;
    bus.d_rd      = 1'b1;
    bus.d_addr    = 32'h0000_0400;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    #1;
    for (int c = 0; c < 12; c++) begin
      exp_if = (c % 3 == 2) && ((c / 3) % 2 == 0);
      exp_d  = (c % 3 == 2) && ((c / 3) % 2 == 1);
      checks++; if ({bus.if_ack, bus.d_ack} !== {exp_if, exp_d}) begin failures++; $display("FAIL b2b_ack_c%0d got=%b exp=%b", c, {bus.if_ack, bus.d_ack}, {exp_if, exp_d}); end
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL b2b_stall_c%0d got=%b exp=1", c, bus.stall); end
      if (c % 3 == 1) begin
        checks++; if (bus.mem_addr !== (((c / 3) % 2 == 0) ? 32'h0000_0300 : 32'h0000_0400)) begin failures++; $display("FAIL b2b_addr_c%0d got=%h", c, bus.mem_addr); end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_drdata = '0;
    test_reset();
    test_fetch();
    test_conflict();
    test_data_access();
    test_timeout();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
